// File: rtl/tt_micro_div_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tt_micro_div_pkg : opcodes, readback selects, FSM state, iterations   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package tt_micro_div_pkg;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_LD_HI = 2'b01;
  localparam logic [1:0] OP_LD_LO = 2'b10;
  localparam logic [1:0] OP_START = 2'b11;

  localparam logic [1:0] SEL_QUOT     = 2'b00;
  localparam logic [1:0] SEL_STATUS   = 2'b01;
  localparam logic [1:0] SEL_DIVIDEND = 2'b10;
  localparam logic [1:0] SEL_DIVISOR  = 2'b11;

  // One quotient bit per BUSY clock, so iterations equal the dividend width.
  localparam int ITERATIONS = 8;
  localparam int CNT_W      = $clog2(ITERATIONS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : tt_micro_div_pkg
`default_nettype wire

// File: rtl/tt_micro_div_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tt_micro_div_core : one combinational restoring-division step         |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tt_micro_div_core
  import tt_micro_div_pkg::*;
(
  input  logic [3:0] part_rem,
  input  logic       dividend_bit,
  input  logic [3:0] divisor,
  output logic [3:0] next_rem,
  output logic       quot_bit
);

  logic [4:0] shifted;

  // part_rem < divisor always holds, so the shifted value fits in 5 bits and
  // any successful subtraction leaves a result that fits back in 4 bits.
  assign shifted  = {part_rem, dividend_bit};
  assign quot_bit = (shifted >= {1'b0, divisor});
  assign next_rem = quot_bit ? (shifted[3:0] - divisor) : shifted[3:0];

endmodule : tt_micro_div_core
`default_nettype wire

// File: rtl/tt_um_micro_div.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tt_um_micro_div : 8b/4b restoring divider tile, registered readback   |
// | optional checker: MICRO_DIV_SELFCHECK_EN                  rev 1.0    |
// +----------------------------------------------------------------------+
module tt_um_micro_div
  import tt_micro_div_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out
);

  logic [1:0] opcode;
  logic [1:0] sel;
  logic [3:0] payload;

  assign opcode  = ui_in[7:6];
  assign sel     = ui_in[5:4];
  assign payload = ui_in[3:0];

  state_t state;
  state_t state_next;

  logic [7:0]            dividend;
  logic [3:0]            divisor;
  logic [7:0]            quotient;
  logic [3:0]            remainder;
  logic                  done;
  logic                  div0;
  logic                  busy;
  logic                  chk_err;

  logic [3:0]            part_rem;
  logic [ITERATIONS-2:0] quot_work;
  logic [CNT_W-1:0]      iter;
  logic [CNT_W-1:0]      bit_idx;

  logic [3:0]            core_rem;
  logic                  core_qbit;
  logic [7:0]            quot_final;
  logic                  last_step;
  logic                  start_ok;
  logic [7:0]            readback;

  assign bit_idx    = CNT_W'(ITERATIONS - 1) - iter;
  assign last_step  = (state == ST_BUSY) && (iter == CNT_W'(ITERATIONS - 1));
  assign start_ok   = (state != ST_BUSY) && (opcode == OP_START);
  assign quot_final = {quot_work, core_qbit};

  tt_micro_div_core u_core (
    .part_rem     (part_rem),
    .dividend_bit (dividend[bit_idx]),
    .divisor      (divisor),
    .next_rem     (core_rem),
    .quot_bit     (core_qbit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (opcode == OP_START)
          state_next = (payload != 4'h0) ? ST_BUSY : ST_DONE;
      end
      ST_BUSY: begin
        if (last_step) state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Partial results live only in part_rem/quot_work; the visible result
  // registers change once, on the final BUSY edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      dividend  <= 8'h00;
      divisor   <= 4'h0;
      quotient  <= 8'h00;
      remainder <= 4'h0;
      done      <= 1'b0;
      div0      <= 1'b0;
      busy      <= 1'b0;
      part_rem  <= 4'h0;
      quot_work <= '0;
      iter      <= '0;
    end else if (state == ST_BUSY) begin
      part_rem  <= core_rem;
      quot_work <= {quot_work[ITERATIONS-3:0], core_qbit};
      iter      <= iter + 1'b1;
      if (last_step) begin
        quotient  <= quot_final;
        remainder <= core_rem;
        done      <= 1'b1;
        busy      <= 1'b0;
      end
    end else begin
      case (opcode)
        OP_LD_HI: dividend[7:4] <= payload;
        OP_LD_LO: dividend[3:0] <= payload;
        OP_START: begin
          divisor <= payload;
          if (payload != 4'h0) begin
            busy      <= 1'b1;
            done      <= 1'b0;
            div0      <= 1'b0;
            part_rem  <= 4'h0;
            quot_work <= '0;
            iter      <= '0;
          end else begin
            quotient  <= 8'hFF;
            remainder <= 4'hF;
            div0      <= 1'b1;
            done      <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MICRO_DIV_SELFCHECK_EN
  logic [11:0] recon;
  logic        chk_bad;

  assign recon   = 12'(quot_final) * 12'(divisor) + 12'(core_rem);
  assign chk_bad = (recon != {4'h0, dividend}) || (core_rem >= divisor);

  always_ff @(posedge clk) begin
    if (rst)            chk_err <= 1'b0;
    else if (start_ok)  chk_err <= 1'b0;
    else if (last_step) chk_err <= chk_bad;
  end
`else
  assign chk_err = 1'b0;
`endif

  always_comb begin
    readback = 8'h00;
    case (sel)
      SEL_QUOT:     readback = quotient;
      SEL_STATUS:   readback = {remainder, chk_err, div0, busy, done};
      SEL_DIVIDEND: readback = dividend;
      default:      readback = {4'h0, divisor};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) uo_out <= 8'h00;
    else     uo_out <= readback;
  end

endmodule : tt_um_micro_div
`default_nettype wire

// File: tb/tb_tt_um_micro_div.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_tt_um_micro_div : scoreboard bench for the nibble divider tile     |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_tt_um_micro_div;

  localparam logic [1:0] NOP   = 2'b00;
  localparam logic [1:0] LD_HI = 2'b01;
  localparam logic [1:0] LD_LO = 2'b10;
  localparam logic [1:0] START = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ui_in;
  logic [7:0] uo_out;

  always #5 clk = ~clk;

  tt_um_micro_div dut (
    .clk    (clk),
    .rst    (rst),
    .ui_in  (ui_in),
    .uo_out (uo_out)
  );

  typedef struct {
    int         cyc;
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t       sb[$];
  int         cyc   = 0;
  int         total = 0;
  int         bad   = 0;
  logic [3:0] last_r;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: uo_out is valid every cycle; compare each entry due by now.
  always @(negedge clk) begin : mon
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      total++;
      if (e.cyc != cyc) begin
        bad++;
        $display("FAIL %s: missed sample at cycle %0d (now %0d)", e.name, e.cyc, cyc);
      end else if (uo_out !== e.val) begin
        bad++;
        $display("FAIL %s: uo_out=0x%02h expected 0x%02h", e.name, uo_out, e.val);
      end
    end
  end

  task automatic drive(input logic [1:0] op, input logic [1:0] sel, input logic [3:0] pay);
    ui_in = {op, sel, pay};
    @(negedge clk);
  endtask

  task automatic push_exp(input logic [7:0] val, input string name);
    exp_t e;
    e.cyc  = cyc + 1;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic expect_read(input logic [1:0] sel, input logic [7:0] val, input string name);
    push_exp(val, name);
    drive(NOP, sel, 4'h0);
  endtask

  task automatic pulse_rst(input string name);
    rst = 1'b1;
    push_exp(8'h00, name);
    drive(START, 2'b10, 4'h5);
    rst = 1'b0;
  endtask

  // Load a, START b, then check busy at the 8th BUSY edge and the result after the 9th.
  task automatic divide(input logic [7:0] a, input logic [3:0] b,
                        input logic [7:0] q, input logic [3:0] r, input string tag);
    drive(LD_HI, 2'b01, a[7:4]);
    drive(LD_LO, 2'b01, a[3:0]);
    drive(START, 2'b01, b);
    if (b == 4'h0) begin
      expect_read(2'b01, {r, 4'b0101}, {tag, " stat"});
      expect_read(2'b00, q,            {tag, " quo"});
    end else begin
      repeat (7) drive(NOP, 2'b01, 4'h0);
      expect_read(2'b01, {last_r, 4'b0010}, {tag, " busy"});
      expect_read(2'b01, {r, 4'b0001},      {tag, " stat"});
      expect_read(2'b00, q,                 {tag, " quo"});
    end
    last_r = r;
  endtask

  initial begin
    rst    = 1'b1;
    ui_in  = 8'h00;
    last_r = 4'h0;
    @(negedge clk);
    pulse_rst("rst hold");
    expect_read(2'b00, 8'h00, "rst quo");
    expect_read(2'b01, 8'h00, "rst stat");
    expect_read(2'b10, 8'h00, "rst dvd");
    expect_read(2'b11, 8'h00, "rst dvs");

    // 200 / 7 = 28 r 4
    divide(8'hC8, 4'h7, 8'h1C, 4'h4, "200/7");
    expect_read(2'b11, 8'h07, "200/7 dvs");
    divide(8'hFF, 4'h1, 8'hFF, 4'h0, "255/1");
    divide(8'h2A, 4'hF, 8'h02, 4'hC, "42/15");

    // Divide by zero, then DONE must survive NOPs and a dividend load.
    divide(8'h0D, 4'h0, 8'hFF, 4'hF, "13/0");
    expect_read(2'b10, 8'h0D, "13/0 dvd");
    repeat (3) drive(NOP, 2'b01, 4'h0);
    expect_read(2'b01, 8'hF5, "done hold");
    drive(LD_LO, 2'b01, 4'h9);
    expect_read(2'b01, 8'hF5, "ld keeps flags");
    expect_read(2'b10, 8'h09, "ld dvd");
    expect_read(2'b00, 8'hFF, "ld keeps quo");

    // 100 / 3 = 33 r 1 with START/LD_LO in BUSY cycles 3 and 4
    drive(LD_HI, 2'b01, 4'h6);
    drive(LD_LO, 2'b01, 4'h4);
    drive(START, 2'b01, 4'h3);
    drive(NOP, 2'b01, 4'h0);
    drive(NOP, 2'b01, 4'h0);
    drive(START, 2'b01, 4'h1);
    drive(LD_LO, 2'b01, 4'h0);
    repeat (3) drive(NOP, 2'b01, 4'h0);
    expect_read(2'b01, {last_r, 4'b0010}, "ign busy");
    expect_read(2'b01, 8'h11, "ign stat");
    expect_read(2'b00, 8'h21, "ign quo");
    expect_read(2'b10, 8'h64, "ign dvd");
    expect_read(2'b11, 8'h03, "ign dvs");
    last_r = 4'h1;

    // Reset in BUSY cycle 5 aborts the division
    drive(START, 2'b01, 4'h3);
    repeat (4) drive(NOP, 2'b01, 4'h0);
    pulse_rst("abort rst");
    expect_read(2'b00, 8'h00, "abort quo");
    expect_read(2'b01, 8'h00, "abort stat");
    expect_read(2'b10, 8'h00, "abort dvd");
    expect_read(2'b11, 8'h00, "abort dvs");
    last_r = 4'h0;
    divide(8'h2A, 4'hF, 8'h02, 4'hC, "post rst");

    // Full operand sweep against a reference model
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        logic [7:0] mq;
        logic [3:0] mr;
        if (b == 0) begin
          mq = 8'hFF;
          mr = 4'hF;
        end else begin
          mq = 8'(a / b);
          mr = 4'(a % b);
        end
        divide(8'(a), 4'(b), mq, mr, $sformatf("sw %0d/%0d", a, b));
      end
    end

    drive(NOP, 2'b00, 4'h0);
    drive(NOP, 2'b00, 4'h0);
    if (sb.size() != 0) begin
      bad++;
      total++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_tt_um_micro_div
`default_nettype wire

// File: doc/tt_um_micro_div.md
TT_UM_MICRO_DIV -- requirements
Module: tt_um_micro_div

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port ui_in, input, 8 bits: [7:6] opcode, [5:4] output select, [3:0] nibble payload.
REQ-004 SHALL have port uo_out, output, 8 bits: registered readback.
REQ-005 SHALL decode opcodes: 00 NOP; 01 LD_HI (dividend[7:4] <= payload); 10 LD_LO (dividend[3:0] <= payload); 11 START (divisor <= payload, begin divide).
REQ-006 SHALL decode select: 00 quotient[7:0]; 01 {remainder[3:0], chk_err, div0, busy, done}; 10 dividend[7:0]; 11 {4'h0, divisor[3:0]}.

Function
REQ-007 SHALL be the inverse of the nibble-multiplier micro tile: unsigned 8-bit dividend / 4-bit divisor -> 8-bit quotient, 4-bit remainder.
REQ-008 SHALL use FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-009 IDLE or DONE, START with divisor != 0 -> BUSY; done and div0 cleared, busy set on the same edge.
REQ-010 BUSY SHALL last exactly 8 clocks (restoring division, one quotient bit per clock, MSB first); 8-bit quotient and 4-bit remainder registers load on the 8th BUSY edge, FSM -> DONE, done=1, busy=0.
REQ-011 START sampled at edge N with divisor != 0 SHALL make done readable via uo_out after edge N+9.
REQ-012 START with divisor == 0 SHALL go directly to DONE: quotient=8'hFF, remainder=4'hF, div0=1, done=1.
REQ-013 LD_HI, LD_LO and START received in BUSY SHALL be ignored; dividend and divisor registers remain stable during BUSY.
REQ-014 LD_HI/LD_LO in IDLE or DONE SHALL update the dividend register only; quotient, remainder and flags are retained until the next START.
REQ-015 DONE SHALL persist until the next START or rst; NOP SHALL not leave DONE.
REQ-016 uo_out SHALL be registered: it equals the select field and state sampled at the previous edge, one-cycle latency, every cycle, in every state.
REQ-017 Quotient, remainder and status bits SHALL not glitch mid-division; intermediate partial results SHALL not be visible on uo_out.

Reset
REQ-018 rst=1 at an edge SHALL clear uo_out, dividend, divisor, quotient, remainder and all flags to 0, and force IDLE, overriding any opcode on that edge.
REQ-019 rst asserted during BUSY SHALL abort the division, with no result written.
REQ-020 The first opcode honored after reset SHALL be the one sampled on the first edge with rst=0.

Configuration
REQ-021 Macro MICRO_DIV_SELFCHECK_EN defined: on entering DONE from BUSY, check quotient*divisor+remainder == dividend and remainder < divisor; set chk_err=1 on mismatch; clear chk_err on START.
REQ-022 Macro MICRO_DIV_SELFCHECK_EN undefined: no checker logic; chk_err SHALL be tied to 0.

Structure
REQ-023 Package tt_micro_div_pkg SHALL hold opcode and select constants, the FSM state type, and the iteration count (8).
REQ-024 Sub-module tt_micro_div_core SHALL hold the combinational restoring-division step: partial remainder, dividend bit and divisor in; next partial remainder and quotient bit out.
REQ-025 Top level SHALL hold the FSM, the operand/result registers, the iteration counter, the output mux and the optional checker.

Verification
REQ-026 LD_HI 0xC, LD_LO 0x8, START 0x7 (200/7) -> after 9 clocks select 00 reads 0x1C; select 01 reads 0x41 (rem 4, done).
REQ-027 Dividend 0xFF, START 0x1 -> quotient 0xFF, remainder 0; dividend 0x2A, START 0xF -> quotient 0x02, remainder 0xC.
REQ-028 Dividend 0x0D, START 0x0 -> next clock select 01 reads 0xF5 (rem F, div0, done); select 00 reads 0xFF.
REQ-029 START 0x3 on dividend 0x64, then START 0x1 and LD_LO 0x0 issued in cycles 3-4 of BUSY -> ignored; result 0x21 rem 1; select 10 still reads 0x64.
REQ-030 rst pulsed in BUSY cycle 5 -> next clock uo_out=0x00, all selects read 0, IDLE; a new START then completes normally.
REQ-031 Sweep all 256x16 operand pairs with MICRO_DIV_SELFCHECK_EN defined -> chk_err never set, and results match a reference model.
